// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, parity and bit-index constants for the UART receive controller
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP,
        DONE   = ST_DONE
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [3:0] START_BIT     = 4'd0;
    localparam logic [3:0] LAST_DATA_BIT = 4'd8;
    localparam logic [3:0] PAR_BIT       = 4'd9;

    // parity bit the transmitter should have sent for this byte
    function automatic logic exp_par(input logic [7:0] d, input logic typ);
        return (^d) ^ (typ == PAR_ODD);
    endfunction

    // states in which a bit is being sampled and the counters run
    function automatic logic is_active(input state_e s);
        return s inside {START, DATA, PARITY, STOP};
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// edge_bit_counter: oversample edge counter and frame bit counter with bit-boundary tick
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] prescale_i,
    output logic [WIDTH-1:0] edge_cnt_o,
    output logic [3:0]       bit_cnt_o,
    output logic             tick_o
);

    logic [WIDTH-1:0] edge_q, edge_d;
    logic [3:0]       bit_q, bit_d;

    assign tick_o     = edge_q == prescale_i - WIDTH'(1);
    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;

    // count edges within a bit, wrapping on the tick; a dropped enable zeroes both counters
    always_comb begin
        edge_d = en_i ? (tick_o ? '0 : edge_q + WIDTH'(1)) : '0;
        bit_d  = en_i ? bit_q + {3'd0, tick_o} : '0;
    end

    // counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame FSM with parity/stop checking and sampler/deserializer enables
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic [WIDTH-1:0] PRESCALE,
    input  logic             SAMPLED_BIT,
    input  logic [7:0]       P_DATA,
    output logic             DAT_SAMP_EN,
    output logic             DESER_EN,
    output logic [WIDTH-1:0] EDGE_CNT,
    output logic [3:0]       BIT_CNT,
    output logic             DATA_VALID,
    output logic             PAR_ERR,
    output logic             STP_ERR
);

    state_e state_q, state_d;
    logic   par_err_q, par_err_d;
    logic   stp_err_q, stp_err_d;
    logic   tick;
    logic   cnt_en;

    // counters run only while staying inside the frame, so they read 0 on entry and after leaving
    assign cnt_en = is_active(state_q) && is_active(state_d);

    edge_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk       (CLK),
        .rst       (RST),
        .en_i      (cnt_en),
        .prescale_i(PRESCALE),
        .edge_cnt_o(EDGE_CNT),
        .bit_cnt_o (BIT_CNT),
        .tick_o    (tick)
    );

    // next-state and error-flag logic
    always_comb begin
        state_d   = state_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        case (state_q)
            IDLE: if (!RX_IN) begin
                state_d   = START;
                par_err_d = 1'b0;
                stp_err_d = 1'b0;
            end
            START:  if (tick) state_d = SAMPLED_BIT ? IDLE : DATA;
            DATA:   if (tick && BIT_CNT == LAST_DATA_BIT) state_d = PAR_EN ? PARITY : STOP;
            PARITY: if (tick) begin
                par_err_d = SAMPLED_BIT ^ exp_par(P_DATA, PAR_TYP);
                state_d   = STOP;
            end
            STOP: if (tick) begin
                stp_err_d = !SAMPLED_BIT;
                state_d   = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and sticky error flag registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign DAT_SAMP_EN = is_active(state_q);
    assign DESER_EN    = state_q == DATA;
    assign DATA_VALID  = state_q == DONE && !par_err_q && !stp_err_q;
    assign PAR_ERR     = par_err_q;
    assign STP_ERR     = stp_err_q;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports CLK and RST.
REQ-002 Parameter: WIDTH, default 6, width of PRESCALE and EDGE_CNT.
REQ-003 Ports SHALL be:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- RX_IN  in  1  serial line, idle high
- PAR_EN  in  1  parity bit present
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- PRESCALE  in  WIDTH  oversampling ratio, legal 4..32
- SAMPLED_BIT  in  1  majority-sampled bit from the data sampler
- P_DATA  in  8  parallel byte from the deserializer
- DAT_SAMP_EN  out  1  sampler enable
- DESER_EN  out  1  deserializer enable
- EDGE_CNT  out  WIDTH  oversample edge count within the current bit
- BIT_CNT  out  4  bit index in frame (0 = start, 1..8 = data, 9 = parity)
- DATA_VALID  out  1  one-cycle pulse: frame received without error
- PAR_ERR  out  1  parity error, sticky until the next start
- STP_ERR  out  1  stop error, sticky until the next start

Function
REQ-004 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and DONE.
REQ-005 Bit boundary: "tick" SHALL be defined as EDGE_CNT == PRESCALE-1, compared at WIDTH bits.
REQ-006 EDGE_CNT SHALL count as follows:
- Held at 0 in IDLE and DONE.
- Otherwise it increments each cycle.
- On a tick it wraps to 0.
REQ-007 BIT_CNT SHALL count as follows:
- Held at 0 in IDLE and DONE.
- Increments by 1 on each tick outside IDLE and DONE.
REQ-008 IDLE -> START SHALL occur on the first cycle RX_IN == 0.
REQ-009 In START, on a tick, the next state SHALL be IDLE if SAMPLED_BIT == 1 (glitch, no flags changed), else DATA.
REQ-010 In DATA, on a tick with BIT_CNT == 8, the next state SHALL be PARITY if PAR_EN == 1, else STOP.
REQ-011 In PARITY, on a tick, PAR_ERR SHALL be set to SAMPLED_BIT XOR (XOR-reduce(P_DATA) XOR PAR_TYP), and the next state SHALL be STOP.
REQ-012 In STOP, on a tick, STP_ERR SHALL be set to NOT SAMPLED_BIT, and the next state SHALL be DONE.
REQ-013 DONE SHALL last exactly one cycle, then go to IDLE.
- DATA_VALID = 1 during DONE iff PAR_ERR == 0 and STP_ERR == 0.
- DATA_VALID = 0 in all other cycles.
REQ-014 PAR_ERR and STP_ERR SHALL clear on the IDLE -> START transition and hold otherwise.
REQ-015 DAT_SAMP_EN SHALL be 1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
REQ-016 DESER_EN SHALL be 1 only in DATA.
REQ-017 All outputs SHALL be registered or decoded from state and counters, with no combinational path from RX_IN.
REQ-018 Latency: DATA_VALID SHALL occur one cycle after the stop-bit tick, giving (10 + PAR_EN) * PRESCALE + 1 cycles from the falling RX_IN edge.
REQ-019 RX_IN == 0 while in DONE SHALL be ignored; it is detected on the next cycle in IDLE (back-to-back frames lose at most one sample).
REQ-020 PRESCALE and PAR_EN SHALL be stable while the state is not IDLE; behaviour on a mid-frame change is unspecified.
REQ-021 PRESCALE < 4 SHALL be unsupported, with no checking required.

Reset
REQ-022 While RST == 1 the block SHALL immediately force:
- state = IDLE;
- EDGE_CNT = 0, BIT_CNT = 0;
- DAT_SAMP_EN = 0, DESER_EN = 0;
- DATA_VALID = 0, PAR_ERR = 0, STP_ERR = 0.
REQ-023 A reset mid-frame SHALL abort the frame with no DATA_VALID, and reception SHALL resume at the first RX_IN == 0 after RST is released.

Structure
REQ-024 Package uart_rx_pkg SHALL hold:
- the state encoding (3-bit, one localparam per state);
- PAR_EVEN = 0 and PAR_ODD = 1;
- the bit-index constants START_BIT = 0, LAST_DATA_BIT = 8 and PAR_BIT = 9.
REQ-025 The counters SHALL be a sub-module, edge_bit_counter (enable, tick output); the FSM and check logic stay in uart_rx_ctrl.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- PRESCALE=8, PAR_EN=0, frame 0x55 with a good stop -> DATA_VALID one cycle at 81 cycles after the start edge; PAR_ERR=0, STP_ERR=0.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, byte 0xA3 with parity bit 0 -> DATA_VALID=1; with parity bit 1 -> PAR_ERR=1, DATA_VALID stays 0.
- PRESCALE=8, stop bit sampled 0 -> STP_ERR=1, no DATA_VALID; flags clear at the next start.
- RX_IN low for 3 cycles then high, SAMPLED_BIT=1 at the tick -> back to IDLE, BIT_CNT=0, flags unchanged.
- RST pulsed at BIT_CNT=5 -> all outputs 0 the same cycle; the following frame 0x0F is received correctly.
- Two back-to-back frames 0x12 and 0x34, PRESCALE=32 -> two DATA_VALID pulses, BIT_CNT sequence 0..8 observed each frame.
